// File: rtl/enemy_palette_lut_if.sv
// Lookup, write and effect-trigger signals of the enemy sprite palette.
// The master side is the sprite fetch/control logic. The slave side is the palette itself.
interface enemy_palette_lut_if #(
    parameter int IDX_W   = 4,
    parameter int BANK_W  = 2,
    parameter int COLOR_W = 8
);
    logic                   rd_valid;
    logic [BANK_W-1:0]      rd_bank;
    logic [IDX_W-1:0]       rd_idx;
    logic                   wr_en;
    logic [BANK_W-1:0]      wr_bank;
    logic [IDX_W-1:0]       wr_idx;
    logic [3*COLOR_W-1:0]   wr_rgb;
    logic                   frame_start;
    logic                   hit;
    logic                   out_valid;
    logic [COLOR_W-1:0]     red;
    logic [COLOR_W-1:0]     green;
    logic [COLOR_W-1:0]     blue;
    logic                   transparent;

    modport master (
        output rd_valid, rd_bank, rd_idx,
        output wr_en, wr_bank, wr_idx, wr_rgb,
        output frame_start, hit,
        input  out_valid, red, green, blue, transparent
    );

    modport slave (
        input  rd_valid, rd_bank, rd_idx,
        input  wr_en, wr_bank, wr_idx, wr_rgb,
        input  frame_start, hit,
        output out_valid, red, green, blue, transparent
    );
endinterface

// File: rtl/enemy_palette_lut.sv
// Multi-bank enemy sprite palette: a writable flop array with a 2-stage registered lookup.
// Defining HIT_FLASH_EN adds a frame-timed white hit-flash on non-transparent pixels.
module enemy_palette_lut #(
    parameter  int IDX_W     = 4,
    parameter  int NUM_BANKS = 4,
    parameter  int COLOR_W   = 8,
    parameter  int FLASH_FR  = 8,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    enemy_palette_lut_if.slave  bus
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int RGB_W   = 3 * COLOR_W;

    function automatic logic [RGB_W-1:0] default_entry(input int idx);
        logic [23:0] c;
        case (idx)
            0:       c = 24'hFFC0CB;
            2:       c = 24'h444653;
            3:       c = 24'h3D3D47;
            4:       c = 24'h57525E;
            5:       c = 24'h918594;
            6:       c = 24'h1E1F27;
            7:       c = 24'h373946;
            8:       c = 24'h3B405D;
            default: c = 24'h000000;
        endcase
        return {COLOR_W'(c[23:16]), COLOR_W'(c[15:8]), COLOR_W'(c[7:0])};
    endfunction

    logic [RGB_W-1:0] palette_reg [NUM_BANKS][ENTRIES];
    logic             wr_sel [NUM_BANKS][ENTRIES];

    // Out-of-range banks never match any strobe, so writes to them are dropped.
    genvar gi, ge;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            for (ge = 0; ge < ENTRIES; ge++) begin : g_entry
                assign wr_sel[gi][ge] = bus.wr_en
                                      && (bus.wr_bank == BANK_W'(gi))
                                      && (bus.wr_idx == IDX_W'(ge));
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (Reset) begin
                    palette_reg[b][e] <= default_entry(e);
                end else if (wr_sel[b][e]) begin
                    palette_reg[b][e] <= bus.wr_rgb;
                end
            end
        end
    end

    // Array data is captured in the same edge that accepts the lookup, so a
    // coincident write to that entry is seen only by later lookups.
    logic             rd_bank_ok;
    logic [RGB_W-1:0] rd_word;

    assign rd_bank_ok = (int'(bus.rd_bank) < NUM_BANKS);

    always_comb begin
        rd_word = '0;
        if (rd_bank_ok) begin
            rd_word = palette_reg[bus.rd_bank][bus.rd_idx];
        end
    end

    logic             s1_valid_reg;
    logic [RGB_W-1:0] s1_rgb_reg;
    logic             s1_transparent_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_reg       <= 1'b0;
            s1_rgb_reg         <= '0;
            s1_transparent_reg <= 1'b0;
        end else begin
            s1_valid_reg       <= bus.rd_valid;
            s1_rgb_reg         <= rd_word;
            s1_transparent_reg <= rd_bank_ok && (bus.rd_idx == '0);
        end
    end

    logic flash_white;

`ifdef HIT_FLASH_EN
    localparam int FCNT_W = $clog2(FLASH_FR + 1);

    logic [FCNT_W-1:0] flash_cnt_reg;
    logic              flash_phase_reg;

    // A hit always restarts the flash, even if it coincides with a frame tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flash_cnt_reg   <= '0;
            flash_phase_reg <= 1'b0;
        end else if (bus.hit) begin
            flash_cnt_reg   <= FCNT_W'(FLASH_FR);
            flash_phase_reg <= 1'b1;
        end else if (bus.frame_start && (flash_cnt_reg != '0)) begin
            flash_cnt_reg   <= flash_cnt_reg - 1'b1;
            flash_phase_reg <= ~flash_phase_reg;
        end
    end

    assign flash_white = (flash_cnt_reg != '0) && flash_phase_reg;
`else
    logic unused_flash_inputs;

    assign unused_flash_inputs = &{1'b0, bus.frame_start, bus.hit};
    assign flash_white         = 1'b0;
`endif

    logic               out_valid_reg;
    logic [COLOR_W-1:0] red_reg;
    logic [COLOR_W-1:0] green_reg;
    logic [COLOR_W-1:0] blue_reg;
    logic               transparent_reg;
    logic [RGB_W-1:0]   out_rgb_next;

    assign out_rgb_next = (flash_white && !s1_transparent_reg) ? '1 : s1_rgb_reg;

    // Colours hold through idle cycles; transparent only qualifies a valid pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_reg   <= 1'b0;
            red_reg         <= '0;
            green_reg       <= '0;
            blue_reg        <= '0;
            transparent_reg <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                red_reg         <= out_rgb_next[3*COLOR_W-1:2*COLOR_W];
                green_reg       <= out_rgb_next[2*COLOR_W-1:COLOR_W];
                blue_reg        <= out_rgb_next[COLOR_W-1:0];
                transparent_reg <= s1_transparent_reg;
            end else begin
                transparent_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.red         = red_reg;
    assign bus.green       = green_reg;
    assign bus.blue        = blue_reg;
    assign bus.transparent = transparent_reg;
endmodule

// File: tb/tb_enemy_palette_lut.sv
// Randomized and directed check of enemy_palette_lut against a lookup-table reference model.
// Define HIT_FLASH_EN for both bench and design to exercise the hit-flash.
module tb_enemy_palette_lut;
    localparam int IDX_W     = 4;
    localparam int NUM_BANKS = 4;
    localparam int BANK_W    = 2;
    localparam int COLOR_W   = 8;
    localparam int FLASH_FR  = 4;
    localparam logic [23:0] DEF_TABLE [9] = '{
        24'hFFC0CB, 24'h000000, 24'h444653, 24'h3D3D47, 24'h57525E,
        24'h918594, 24'h1E1F27, 24'h373946, 24'h3B405D};

    logic clk;
    logic reset;

    enemy_palette_lut_if #(.IDX_W(IDX_W), .BANK_W(BANK_W), .COLOR_W(COLOR_W)) bus ();

    enemy_palette_lut #(
        .IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS), .COLOR_W(COLOR_W), .FLASH_FR(FLASH_FR)
    ) dut (
        .Clk(clk),
        .Reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: palette contents, results of the last two requests, visible outputs.
    typedef struct {
        bit          valid;
        logic [23:0] rgb;
        bit          tr;
    } req_t;

    logic [23:0] m_pal [NUM_BANKS][16];
    req_t        m_pend;
    bit          m_ov;
    logic [23:0] m_rgb;
    bit          m_tr;
    int          m_fcnt;
    bit          m_phase;

    function automatic logic [23:0] def_rgb(input int idx);
        return (idx < 9) ? DEF_TABLE[idx] : 24'h000000;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NUM_BANKS; b++)
            for (int e = 0; e < 16; e++)
                m_pal[b][e] = def_rgb(e);
        m_pend  = '{valid: 1'b0, rgb: 24'h0, tr: 1'b0};
        m_ov    = 1'b0;
        m_rgb   = 24'h0;
        m_tr    = 1'b0;
        m_fcnt  = 0;
        m_phase = 1'b0;
    endtask

    function automatic logic [23:0] dut_rgb();
        return {bus.red, bus.green, bus.blue};
    endfunction

    // One clock: work out the post-edge model state from pre-edge state, then compare.
    task automatic cycle();
        req_t        n_pend;
        bit          white;
        if (reset) begin
            model_reset();
        end else begin
            white = 1'b0;
`ifdef HIT_FLASH_EN
            white = (m_fcnt > 0) && m_phase;
`endif
            m_ov = m_pend.valid;
            if (m_pend.valid) begin
                m_rgb = (white && !m_pend.tr) ? 24'hFFFFFF : m_pend.rgb;
                m_tr  = m_pend.tr;
            end else begin
                m_tr  = 1'b0;
            end
            n_pend.valid = bus.rd_valid;
            n_pend.rgb   = m_pal[bus.rd_bank][bus.rd_idx];
            n_pend.tr    = (bus.rd_idx == 0);
            m_pend = n_pend;
            if (bus.wr_en)
                m_pal[bus.wr_bank][bus.wr_idx] = bus.wr_rgb;
`ifdef HIT_FLASH_EN
            if (bus.hit) begin
                m_fcnt  = FLASH_FR;
                m_phase = 1'b1;
            end else if (bus.frame_start && m_fcnt > 0) begin
                m_fcnt  = m_fcnt - 1;
                m_phase = !m_phase;
            end
`endif
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
        check_eq("rgb", 32'(dut_rgb()), 32'(m_rgb));
        check_eq("transparent", 32'(bus.transparent), 32'(m_tr));
        if (m_ov)
            $display("txn out rgb=%06h transparent=%0d", dut_rgb(), bus.transparent);
    endtask

    task automatic idle_inputs();
        bus.rd_valid    = 1'b0;
        bus.wr_en       = 1'b0;
        bus.frame_start = 1'b0;
        bus.hit         = 1'b0;
    endtask

    task automatic lookup(input int bank, input int idx);
        bus.rd_valid = 1'b1;
        bus.rd_bank  = BANK_W'(bank);
        bus.rd_idx   = IDX_W'(idx);
        cycle();
        bus.rd_valid = 1'b0;
    endtask

    // Issue a single lookup, then wait for its result at the outputs.
    task automatic lookup_wait(input int bank, input int idx);
        lookup(bank, idx);
        cycle();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

`ifdef HIT_FLASH_EN
    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.rd_bank = '0;
        bus.rd_idx  = '0;
        bus.wr_bank = '0;
        bus.wr_idx  = '0;
        bus.wr_rgb  = '0;
        idle_inputs();
        model_reset();
        do_reset();
        check_eq("reset_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset_rgb", 32'(dut_rgb()), 32'd0);

        for (int i = 1; i <= 8; i++) lookup(0, i);
        cycle();
        cycle();

        lookup_wait(2, 0);
        check_eq("b2_idx0_rgb", 32'(dut_rgb()), 32'hFFC0CB);
        check_eq("b2_idx0_tr", 32'(bus.transparent), 32'd1);
        lookup_wait(2, 5);
        check_eq("b2_idx5_rgb", 32'(dut_rgb()), 32'h918594);
        check_eq("b2_idx5_tr", 32'(bus.transparent), 32'd0);

        bus.wr_en   = 1'b1;
        bus.wr_bank = 2'd1;
        bus.wr_idx  = 4'd3;
        bus.wr_rgb  = 24'h123456;
        lookup(1, 3);
        bus.wr_en = 1'b0;
        cycle();
        check_eq("rbw_old", 32'(dut_rgb()), 32'h3D3D47);
        lookup_wait(1, 3);
        check_eq("rbw_new", 32'(dut_rgb()), 32'h123456);

        lookup(0, 4);
        cycle();
        lookup(0, 6);
        lookup(0, 7);
        cycle();
        cycle();
        cycle();

        for (int i = 0; i < 4; i++) lookup(3, i + 2);
        bus.rd_valid = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        bus.rd_valid = 1'b0;
        check_eq("midreset_valid", 32'(bus.out_valid), 32'd0);
        cycle();
        cycle();

        for (int i = 0; i < 400; i++) begin
            bus.rd_valid    = ($urandom_range(0, 3) != 0);
            bus.rd_bank     = BANK_W'($urandom_range(0, NUM_BANKS - 1));
            bus.rd_idx      = IDX_W'($urandom_range(0, 15));
            bus.wr_en       = ($urandom_range(0, 3) == 0);
            bus.wr_bank     = BANK_W'($urandom_range(0, NUM_BANKS - 1));
            bus.wr_idx      = IDX_W'($urandom_range(0, 15));
            bus.wr_rgb      = 24'($urandom);
            bus.frame_start = ($urandom_range(0, 7) == 0);
            bus.hit         = ($urandom_range(0, 31) == 0);
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

`ifdef HIT_FLASH_EN
        do_reset();
        bus.hit = 1'b1;
        cycle();
        bus.hit = 1'b0;
        lookup_wait(0, 2);
        check_eq("flash_f0", 32'(dut_rgb()), 32'hFFFFFF);
        pulse_frame();
        lookup_wait(0, 2);
        check_eq("flash_f1", 32'(dut_rgb()), 32'h444653);
        pulse_frame();
        lookup_wait(0, 2);
        check_eq("flash_f2", 32'(dut_rgb()), 32'hFFFFFF);
        pulse_frame();
        lookup_wait(0, 2);
        check_eq("flash_f3", 32'(dut_rgb()), 32'h444653);
        pulse_frame();
        lookup_wait(0, 2);
        check_eq("flash_done", 32'(dut_rgb()), 32'h444653);
        lookup_wait(0, 0);
        check_eq("flash_tr_colour", 32'(dut_rgb()), 32'hFFC0CB);

        bus.hit = 1'b1;
        cycle();
        bus.hit = 1'b0;
        pulse_frame();
        pulse_frame();
        pulse_frame();
        bus.hit = 1'b1;
        cycle();
        bus.hit = 1'b0;
        lookup_wait(0, 2);
        check_eq("rehit_white", 32'(dut_rgb()), 32'hFFFFFF);
        pulse_frame();
        pulse_frame();
        lookup_wait(0, 2);
        check_eq("rehit_restart", 32'(dut_rgb()), 32'hFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
